// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
//   Multi-cycle 32x32 unsigned multiply / divide sequencer that borrows the
//   shared EX-stage ALU while busy. Multiply is shift-add using ALU ADD;
//   divide is restoring division using ALU SUB. Results land in hi/lo.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start, op, opa, opb request (op: 0 = mul, 1 = div), sampled only in IDLE
//   busy, done          busy while iterating; done is a one-cycle result pulse
//   hi, lo              MUL: product[63:32] / product[31:0]; DIV: rem / quot
//   div_by_zero         divide started with opb == 0, held with hi/lo
//   alu_ctrl/in1/in2    request driven to the shared ALU
//   alu_out             combinational ALU result (same cycle)
module alu_muldiv_seq #(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] CTRL_ADD = 4'd2,
    parameter logic [3:0] CTRL_SUB = 4'd6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    // Multiplicand for MUL, divisor for DIV: never needed at the same time.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] shift_rem;
    logic             carry;
    logic             sub_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            op_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        dbz_d    = dbz_q;
        alu_ctrl = CTRL_ADD;
        alu_in1  = '0;
        alu_in2  = '0;

        // Partial remainder shifted left by one with the next dividend bit;
        // hi_q[WIDTH-1] is the bit that falls off the top (33rd bit of s).
        shift_rem = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        // Carry out of hi + mcand, recovered from the wrapped 32-bit sum.
        carry     = (alu_out < hi_q);
        // If the shifted-out top bit is set the 33-bit remainder is surely
        // >= divisor, and the 32-bit ALU difference is still exact.
        sub_ok    = hi_q[WIDTH-1] | (shift_rem >= opnd_q);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    dbz_d = 1'b0;
                    if (op && (opb == '0)) begin
                        hi_d    = opa;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        hi_d    = '0;
                        lo_d    = opa;
                        opnd_d  = opb;
                        count_d = '0;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (!op_q) begin
                    alu_ctrl = CTRL_ADD;
                    alu_in1  = hi_q;
                    alu_in2  = opnd_q;
                    // {hi,lo} shifts right one; multiplier bits leave lo[0]
                    // while product bits enter lo[31].
                    if (lo_q[0]) begin
                        hi_d = {carry, alu_out[WIDTH-1:1]};
                        lo_d = {alu_out[0], lo_q[WIDTH-1:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[WIDTH-1:1]};
                        lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
                    end
                end else begin
                    alu_ctrl = CTRL_SUB;
                    alu_in1  = shift_rem;
                    alu_in2  = opnd_q;
                    if (sub_ok) begin
                        hi_d = alu_out;
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = shift_rem;
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end
                count_d = count_q + 1'b1;
                if (count_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
